// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding a UART transmitter. Sends one tx_start strobe
//            per byte and back-to-back bytes on tx_done.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    input  logic                     flush,
    output logic                     tx_start,
    output logic [7:0]               tx_din,
    input  logic                     tx_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [7:0]    r_mem [DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          r_tx_start;
    logic [7:0]    r_tx_din;
    logic [c_AW:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Status comes from the registered pointers only, so it lags a push/pop by one edge.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == c_FULL_CNT);
    assign s_ready  = !w_full && !flush;
    assign w_push   = s_valid && s_ready;

    assign count    = w_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign tx_start = r_tx_start;
    assign tx_din   = r_tx_din;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Flush wins over a pop; the popped byte is already latched into tx_din.
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_din   <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_din <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

    // tx_done is only honoured in BUSY and never in the strobe cycle itself.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (tx_done && !r_tx_start) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       flush   = 1'b0;
    logic       tx_done = 1'b0;
    logic       s_ready;
    logic       tx_start;
    logic [7:0] tx_din;
    logic [$clog2(DEPTH):0] count;
    logic       empty;
    logic       full;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sent_q [$];

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .flush    (flush),
        .tx_start (tx_start),
        .tx_din   (tx_din),
        .tx_done  (tx_done),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Every strobed byte is logged so transmit order can be compared later.
    always @(negedge clk) begin
        if (tx_start === 1'b1) sent_q.push_back(tx_din);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves s_valid high so consecutive calls form a continuous stream.
    task automatic push_byte(input logic [7:0] b);
        logic acc;
        int   bud;
        s_valid = 1'b1;
        s_data  = b;
        bud     = 0;
        do begin
            acc = s_ready;
            tick(1);
            bud++;
        end while (!acc && bud < 200);
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp3 [5];
        exp3[0] = 8'hB0; exp3[1] = 8'hB1; exp3[2] = 8'hB2; exp3[3] = 8'hB3; exp3[4] = 8'hB4;

        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_count",   32'(count),    32'd0);
        check("rst_empty",   32'(empty),    32'd1);
        check("rst_full",    32'(full),     32'd0);
        check("rst_s_ready", 32'(s_ready),  32'd1);
        check("rst_start",   32'(tx_start), 32'd0);
        check("rst_din",     32'(tx_din),   32'h00);

        // Single byte latency
        push_byte(8'hA5);
        s_valid = 1'b0;
        check("single_cnt1",   32'(count),    32'd1);
        check("single_nostart",32'(tx_start), 32'd0);
        tick(1);
        check("single_start",  32'(tx_start), 32'd1);
        check("single_din",    32'(tx_din),   32'hA5);
        check("single_cnt0",   32'(count),    32'd0);
        tick(1);
        check("single_start_off", 32'(tx_start), 32'd0);
        check("single_din_hold",  32'(tx_din),   32'hA5);
        tick(3);
        done_pulse();
        tick(5);
        done_pulse();
        tick(3);
        check("single_nsent", 32'(sent_q.size()), 32'd1);
        check("single_byte",  32'(sent_q[0]),     32'hA5);

        // Fill: 00 in flight, 01..10 buffered, 11 stalled
        sent_q.delete();
        for (int b = 0; b < 17; b++) push_byte(8'(b));
        s_data = 8'h11;
        tick(3);
        check("fill_full",    32'(full),    32'd1);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        check("fill_count",   32'(count),   32'd16);
        check("fill_nsent",   32'(sent_q.size()), 32'd1);

        fork
            begin : offer_11
                int bud = 0;
                while (!s_ready && bud < 400) begin
                    tick(1);
                    bud++;
                end
                if (!s_ready) check("fill_11_timeout", 32'd0, 32'd1);
                tick(1);
                s_valid = 1'b0;
            end
            begin : drain
                for (int i = 0; i < 18; i++) begin
                    tick(9);
                    done_pulse();
                    check("b2b_start", 32'(tx_start), 32'(i < 17));
                    if (i < 17) check("b2b_din", 32'(tx_din), 32'(i + 1));
                end
            end
        join
        tick(5);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_nsent", 32'(sent_q.size()), 32'd18);
        for (int i = 0; i < 18 && i < sent_q.size(); i++) check("drain_order", 32'(sent_q[i]), 32'(i));

        // Push coincident with a tx_done pop
        sent_q.delete();
        push_byte(8'hB0); push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3);
        s_valid = 1'b0;
        tick(3);
        check("sim_cnt_before", 32'(count), 32'd3);
        s_valid = 1'b1;
        s_data  = 8'hB4;
        tx_done = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tx_done = 1'b0;
        check("sim_cnt_after", 32'(count),    32'd3);
        check("sim_start",     32'(tx_start), 32'd1);
        check("sim_din",       32'(tx_din),   32'hB1);
        for (int i = 0; i < 4; i++) begin
            tick(4);
            done_pulse();
        end
        tick(3);
        check("sim_nsent", 32'(sent_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < sent_q.size(); i++) check("sim_order", 32'(sent_q[i]), 32'(exp3[i]));

        // Flush while BUSY with 3C in flight
        sent_q.delete();
        push_byte(8'h3C); push_byte(8'h41); push_byte(8'h42); push_byte(8'h43); push_byte(8'h44);
        s_valid = 1'b0;
        tick(3);
        check("flush_cnt_before", 32'(count), 32'd4);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        tick(1);
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_count", 32'(count),  32'd0);
        check("flush_empty", 32'(empty),  32'd1);
        check("flush_din",   32'(tx_din), 32'h3C);
        tick(2);
        done_pulse();
        check("flush_nostart", 32'(tx_start), 32'd0);
        tick(5);
        check("flush_nsent", 32'(sent_q.size()), 32'd1);

        // Flush on the same edge as the IDLE pop
        sent_q.delete();
        push_byte(8'h60);
        s_valid = 1'b0;
        flush   = 1'b1;
        tick(1);
        flush   = 1'b0;
        check("flushpop_start", 32'(tx_start), 32'd1);
        check("flushpop_din",   32'(tx_din),   32'h60);
        check("flushpop_count", 32'(count),    32'd0);
        tick(3);
        done_pulse();
        tick(3);

        // Reset mid-BUSY with 5 buffered
        sent_q.delete();
        for (int b = 0; b < 6; b++) push_byte(8'(8'h80 + b));
        s_valid = 1'b0;
        tick(3);
        check("rstb_cnt_before", 32'(count), 32'd5);
        rst = 1'b1;
        #1;
        check("rstb_start",   32'(tx_start), 32'd0);
        check("rstb_din",     32'(tx_din),   32'h00);
        check("rstb_count",   32'(count),    32'd0);
        check("rstb_empty",   32'(empty),    32'd1);
        check("rstb_s_ready", 32'(s_ready),  32'd1);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rstb_nsent", 32'(sent_q.size()), 32'd1);
        push_byte(8'h77);
        s_valid = 1'b0;
        tick(1);
        check("rstb_new_start", 32'(tx_start), 32'd1);
        check("rstb_new_din",   32'(tx_din),   32'h77);
        tick(1);
        check("rstb_new_off",   32'(tx_start), 32'd0);
        done_pulse();
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
